// File: rtl/timer_counter.sv
// timer_counter: memory-mapped countdown timer with one-shot and auto-reload
// modes and a maskable, level-held interrupt request.
//
// Register map (word select addr):
//   0 CTRL   [0]=EN, [2:1]=MODE (01 auto-reload, anything else one-shot), [3]=IM
//   1 PRESET full 32-bit read/write
//   2 COUNT  read-only
//   3 reserved, reads 0
//
// Optional build macro TIMER_PRESCALE_EN: when defined, decrements in CNT are
// gated to once every PRESCALE_DIV clk cycles by a 16-bit prescale counter.
// When undefined, COUNT decrements every cycle and no prescale logic exists.
//
// Bus handshake: there is no valid/ready pair on this port. A store is a
// single-cycle we pulse sampled on the rising clk edge, always accepted;
// loads are a combinational read of the register selected by addr.
module timer_counter #(
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        ctrl_wr;
  logic        preset_wr;
  logic        cpu_wr;
  logic [3:0]  ctrl_new;
  logic        auto_new;
  logic        dec_tick;

  // Decode CPU stores; ctrl_new is the CTRL value this cycle's store would
  // leave behind, so the counting FSM reacts to a write on the same edge.
  always_comb begin
    ctrl_wr   = we && (addr == ADDR_CTRL);
    preset_wr = we && (addr == ADDR_PRESET);
    cpu_wr    = ctrl_wr || preset_wr;
    ctrl_new  = ctrl_wr ? wdata[3:0] : ctrl_q;
    auto_new  = (ctrl_new[2:1] == 2'b01);
  end

`ifdef TIMER_PRESCALE_EN
  localparam logic [15:0] PRE_LAST = 16'(PRESCALE_DIV - 1);

  logic [15:0] pre_q, pre_d;

  // Prescale counter: cleared in LOAD, advances only while counting with EN set.
  always_comb begin
    pre_d    = pre_q;
    dec_tick = (pre_q == PRE_LAST);
    if (state_q == ST_LOAD) begin
      pre_d = 16'd0;
    end else if ((state_q == ST_CNT) && ctrl_new[0]) begin
      pre_d = dec_tick ? 16'd0 : pre_q + 16'd1;
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk) begin
    if (reset) pre_q <= 16'd0;
    else       pre_q <= pre_d;
  end
`else
  assign dec_tick = 1'b1;
`endif

  // Next-state logic: FSM, COUNT, interrupt flag and CPU-visible registers.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_new;
    preset_d   = preset_wr ? wdata : preset_q;
    count_d    = count_q;
    // Any store to CTRL or PRESET acknowledges the interrupt.
    irq_flag_d = cpu_wr ? 1'b0 : irq_flag_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_q[0]) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_new[0]) begin
          state_d = ST_IDLE;
        end else if (dec_tick) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            // PRESET=0 lands here too, so it behaves like PRESET=1.
            count_d = 32'd0;
            // A simultaneous store wins: the flag stays clear.
            if (!cpu_wr) irq_flag_d = 1'b1;
            state_d = ST_INT;
          end
        end
      end
      ST_INT: begin
        state_d = ST_IDLE;
        if (auto_new) begin
          // Auto-reload: the flag is a single-cycle pulse.
          if (!cpu_wr) irq_flag_d = 1'b0;
        end else if (!ctrl_wr) begin
          // One-shot: stop the timer, leave the flag held.
          ctrl_d[0] = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Combinational register read mux and masked interrupt output.
  always_comb begin
    rdata = 32'd0;
    unique case (addr)
      ADDR_CTRL:   rdata = {28'd0, ctrl_q};
      ADDR_PRESET: rdata = preset_q;
      ADDR_COUNT:  rdata = count_q;
      default:     rdata = 32'd0;
    endcase
    irq = irq_flag_q & ctrl_q[3];
  end

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed bench for timer_counter (default build).
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_bad    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] v;

  timer_counter #(.PRESCALE_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] val);
    addr = a;
    #1;
    val = rdata;
  endtask

  // Scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = 32'd0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      check($sformatf("reset_rd%0d", a), v, 32'd0);
    end
    check_irq("reset_irq", 1'b0);

    // COUNT/reserved writes ignored, CTRL upper bits read 0
    wr(2'd2, 32'hDEAD_BEEF);
    wr(2'd3, 32'h1234_5678);
    wr(2'd0, 32'hFFFF_FFF0);
    rd(2'd2, v); check("count_ro", v, 32'd0);
    rd(2'd3, v); check("rsvd_ro", v, 32'd0);
    rd(2'd0, v); check("ctrl_hi0", v, 32'd0);
    wr(2'd0, 32'd0);

    // One-shot, PRESET=5, IM=1
    wr(2'd1, 32'd5);
    rd(2'd1, v); check("preset_rd", v, 32'd5);
    wr(2'd0, 32'h9);
    step(); step();
    for (int k = 5; k >= 0; k--) exp_q.push_back(32'(k));
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      rd(2'd2, v);
      check("os_count", v, e);
      check_irq("os_irq", (e == 32'd0));
      if (e != 32'd0) step();
    end
    step();
    rd(2'd0, v); check("os_ctrl_en_clr", v, 32'h8);
    check_irq("os_irq_held", 1'b1);
    repeat (3) step();
    check_irq("os_irq_held2", 1'b1);
    rd(2'd2, v); check("os_count_hold0", v, 32'd0);
    wr(2'd0, 32'h8);
    check_irq("os_ack", 1'b0);

    // Auto-reload, PRESET=3, IM=1: period 6
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    step(); step();
    for (int k = 0; k < 18; k++) begin
      logic [31:0] ec;
      case (k % 6)
        0: ec = 32'd3;
        1: ec = 32'd2;
        2: ec = 32'd1;
        default: ec = 32'd0;
      endcase
      rd(2'd2, v);
      check($sformatf("ar_count%0d", k), v, ec);
      check_irq($sformatf("ar_irq%0d", k), (k % 6) == 3);
      step();
    end
    wr(2'd0, 32'h0);
    repeat (3) step();

    // IM=0: flag set but masked, then CTRL write clears it
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h1);
    step(); step();
    rd(2'd2, v); check("im0_load", v, 32'd4);
    repeat (4) step();
    rd(2'd2, v); check("im0_zero", v, 32'd0);
    check_irq("im0_irq", 1'b0);
    step();
    wr(2'd0, 32'h8);
    check_irq("im0_unmask", 1'b0);
    step();
    check_irq("im0_unmask2", 1'b0);

    // Stop mid-count with COUNT=2
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h9);
    step(); step();
    repeat (4) step();
    rd(2'd2, v); check("stop_pre", v, 32'd2);
    wr(2'd0, 32'h0);
    rd(2'd2, v); check("stop_freeze", v, 32'd2);
    repeat (5) step();
    rd(2'd2, v); check("stop_hold", v, 32'd2);
    check_irq("stop_irq", 1'b0);

    // Reset mid-count with COUNT=2
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h9);
    step(); step();
    repeat (4) step();
    rd(2'd2, v); check("rst_pre", v, 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd(2'd0, v); check("rst_ctrl", v, 32'd0);
    rd(2'd1, v); check("rst_preset", v, 32'd0);
    rd(2'd2, v); check("rst_count", v, 32'd0);
    check_irq("rst_irq", 1'b0);
    repeat (4) step();
    rd(2'd2, v); check("rst_idle", v, 32'd0);
    check_irq("rst_idle_irq", 1'b0);

    // PRESET=0 behaves as PRESET=1
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    step(); step();
    check_irq("p0_load_irq", 1'b0);
    step();
    check_irq("p0_irq", 1'b1);
    wr(2'd0, 32'h0);
    check_irq("p0_ack", 1'b0);
    repeat (3) step();

    // PRESET store on the same edge COUNT reaches zero: no irq
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    step(); step();
    step(); step();
    rd(2'd2, v); check("sim_pre", v, 32'd1);
    wr(2'd1, 32'd7);
    rd(2'd2, v); check("sim_count", v, 32'd0);
    check_irq("sim_irq", 1'b0);
    step();
    check_irq("sim_irq2", 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
